// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs
// and datapath select/ALU encodings.
package mips_mc_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EX_R    = 4'd2,
    WB_R    = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    WB_LW   = 4'd6,
    MEM_WR  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    JAL     = 4'd10,
    JR      = 4'd11,
    EX_I    = 4'd12,
    WB_I    = 4'd13
  } state_t;

  // ALU-op class handed from the FSM to the ALU control decoder
  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2,
    ALU_CLS_SLT   = 2'd3
  } alu_class_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNC_W-1:0] FN_JR  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_REGA   = 2'b11;

  localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

  localparam logic [SEL_W-1:0] WD_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] WD_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] WD_PC     = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  // R-type functs that the EX_R state can execute
  function automatic logic rtype_alu_legal(input logic [FUNC_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and zero flag in, control lines out.
interface mips_mc_controller_if;
  import mips_mc_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  logic                zero;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic [SEL_W-1:0]    RegDst;
  logic [SEL_W-1:0]    data_to_write;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [SEL_W-1:0]    ALUSrcB;
  logic [ALUOP_W-1:0]  alu_operation;
  logic [SEL_W-1:0]    PCSrc;
  logic                illegal_op;
  logic [STATE_W-1:0]  state;

  modport master (
    input  opcode, func, zero,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           data_to_write, RegWrite, ALUSrcA, ALUSrcB, alu_operation, PCSrc,
           illegal_op, state
  );

  modport slave (
    output opcode, func, zero,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
           data_to_write, RegWrite, ALUSrcA, ALUSrcB, alu_operation, PCSrc,
           illegal_op, state
  );

endinterface

// File: rtl/mc_alu_control.sv
// ALU control decoder: ALU-op class plus funct -> alu_operation (combinational).
module mc_alu_control
  import mips_mc_pkg::*;
(
  input  alu_class_t           alu_class,
  input  logic [FUNC_W-1:0]    func,
  output logic [ALUOP_W-1:0]   alu_operation
);

  // Class decode; funct-driven ops fall back to add for unlisted functs
  always_comb begin
    alu_operation = ALU_ADD;
    case (alu_class)
      ALU_CLS_ADD: alu_operation = ALU_ADD;
      ALU_CLS_SUB: alu_operation = ALU_SUB;
      ALU_CLS_SLT: alu_operation = ALU_SLT;
      ALU_CLS_FUNCT: begin
        case (func)
          FN_ADD:  alu_operation = ALU_ADD;
          FN_SUB:  alu_operation = ALU_SUB;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_SLT:  alu_operation = ALU_SLT;
          default: alu_operation = ALU_ADD;
        endcase
      end
      default: alu_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and enables.
// Optional feature macro: MC_JUMP_LINK_EN enables the JAL and JR states.
module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_controller_if.master bus
);

  state_t             state_q;
  state_t             state_d;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic [SEL_W-1:0]   reg_dst;
  logic [SEL_W-1:0]   wdata_sel;
  logic               reg_write;
  logic               src_a;
  logic [SEL_W-1:0]   src_b;
  logic               alu_use;
  alu_class_t         alu_cls;
  logic [ALUOP_W-1:0] alu_op_raw;
  logic [SEL_W-1:0]   pc_src;
  logic               illegal;

  mc_alu_control u_alu_control (
    .alu_class     (alu_cls),
    .func          (bus.func),
    .alu_operation (alu_op_raw)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REGDST_RT;
    wdata_sel     = WD_ALUOUT;
    reg_write     = 1'b0;
    src_a         = 1'b0;
    src_b         = SRCB_REGB;
    alu_use       = 1'b0;
    alu_cls       = ALU_CLS_ADD;
    pc_src        = PCSRC_ALU;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        src_b    = SRCB_FOUR;
        alu_use  = 1'b1;
        pc_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        src_b   = SRCB_IMM_SH2;
        alu_use = 1'b1;
        state_d = FETCH;
        case (bus.opcode)
          OP_RTYPE: begin
`ifdef MC_JUMP_LINK_EN
            if (bus.func == FN_JR)                state_d = JR;
            else if (rtype_alu_legal(bus.func))   state_d = EX_R;
            else                                  illegal = 1'b1;
`else
            if (rtype_alu_legal(bus.func))        state_d = EX_R;
            else                                  illegal = 1'b1;
`endif
          end
          OP_LW, OP_SW:     state_d = MEM_ADR;
          OP_BEQ:           state_d = BRANCH;
          OP_ADDI, OP_SLTI: state_d = EX_I;
          OP_J:             state_d = JUMP;
`ifdef MC_JUMP_LINK_EN
          OP_JAL:           state_d = JAL;
`endif
          default:          illegal = 1'b1;
        endcase
      end
      EX_R: begin
        src_a   = 1'b1;
        alu_use = 1'b1;
        alu_cls = ALU_CLS_FUNCT;
        state_d = WB_R;
      end
      WB_R: begin
        reg_dst   = REGDST_RD;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADR: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu_use = 1'b1;
        state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = WB_LW;
      end
      WB_LW: begin
        wdata_sel = WD_MDR;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        src_a         = 1'b1;
        alu_use       = 1'b1;
        alu_cls       = ALU_CLS_SUB;
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
`ifdef MC_JUMP_LINK_EN
      JAL: begin
        pc_src    = PCSRC_JUMP;
        pc_write  = 1'b1;
        reg_dst   = REGDST_RA;
        wdata_sel = WD_PC;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JR: begin
        pc_src   = PCSRC_REGA;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
`endif
      EX_I: begin
        src_a   = 1'b1;
        src_b   = SRCB_IMM;
        alu_use = 1'b1;
        alu_cls = (bus.opcode == OP_SLTI) ? ALU_CLS_SLT : ALU_CLS_ADD;
        state_d = WB_I;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs forced low while reset is held so no strobe escapes mid-instruction
  assign bus.PCWrite       = rst & pc_write;
  assign bus.PCWriteCond   = rst & pc_write_cond;
  assign bus.IorD          = rst & iord;
  assign bus.MemRead       = rst & mem_read;
  assign bus.MemWrite      = rst & mem_write;
  assign bus.IRWrite       = rst & ir_write;
  assign bus.RegDst        = rst ? reg_dst : REGDST_RT;
  assign bus.data_to_write = rst ? wdata_sel : WD_ALUOUT;
  assign bus.RegWrite      = rst & reg_write;
  assign bus.ALUSrcA       = rst & src_a;
  assign bus.ALUSrcB       = rst ? src_b : SRCB_REGB;
  assign bus.alu_operation = (rst && alu_use) ? alu_op_raw : ALUOP_W'(0);
  assign bus.PCSrc         = rst ? pc_src : PCSRC_ALU;
  assign bus.illegal_op    = rst & illegal;
  assign bus.state         = rst ? STATE_W'(state_q) : STATE_W'(FETCH);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed self-checking bench for mips_mc_controller (both MC_JUMP_LINK_EN builds).
module tb_mips_mc_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [19:0] out_word;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_word = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.RegDst, bus.data_to_write,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.alu_operation,
                     bus.PCSrc, bus.illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_check(input string tag);
    check({tag, "_state"},  32'(bus.state), 32'd0);
    check({tag, "_memrd"},  32'(bus.MemRead), 32'd1);
    check({tag, "_irw"},    32'(bus.IRWrite), 32'd1);
    check({tag, "_pcw"},    32'(bus.PCWrite), 32'd1);
    check({tag, "_regw"},   32'(bus.RegWrite), 32'd0);
    check({tag, "_ill"},    32'(bus.illegal_op), 32'd0);
  endtask

  task automatic decode_check(input string tag, input logic ill);
    check({tag, "_dec_state"}, 32'(bus.state), 32'd1);
    check({tag, "_dec_alu"},   32'(bus.alu_operation), 32'b010);
    check({tag, "_dec_srcb"},  32'(bus.ALUSrcB), 32'b11);
    check({tag, "_dec_ill"},   32'(bus.illegal_op), 32'(ill));
  endtask

  localparam int NR = 5;
  logic [5:0] r_func [NR] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] r_alu  [NR] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    bus.opcode = 6'd0;
    bus.func   = 6'd0;
    bus.zero   = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_outs",  32'(out_word), 32'd0);
    end
    rst = 1'b1;
    #1;
    fetch_check("first_fetch");

    // R-type ALU ops
    for (int i = 0; i < NR; i++) begin
      bus.opcode = 6'b000000;
      bus.func   = r_func[i];
      tick(); decode_check("rtype", 1'b0);
      tick();
      check("exr_state", 32'(bus.state), 32'd2);
      check("exr_alu",   32'(bus.alu_operation), 32'(r_alu[i]));
      check("exr_srca",  32'(bus.ALUSrcA), 32'd1);
      check("exr_srcb",  32'(bus.ALUSrcB), 32'b00);
      check("exr_regw",  32'(bus.RegWrite), 32'd0);
      tick();
      check("wbr_state", 32'(bus.state), 32'd3);
      check("wbr_regw",  32'(bus.RegWrite), 32'd1);
      check("wbr_regdst", 32'(bus.RegDst), 32'b01);
      check("wbr_wd",    32'(bus.data_to_write), 32'b00);
      tick(); fetch_check("r_fetch");
    end

    // lw
    bus.opcode = 6'b100011;
    tick(); decode_check("lw", 1'b0);
    tick();
    check("lw_adr_state", 32'(bus.state), 32'd4);
    check("lw_adr_alu",   32'(bus.alu_operation), 32'b010);
    check("lw_adr_srcb",  32'(bus.ALUSrcB), 32'b10);
    check("lw_adr_srca",  32'(bus.ALUSrcA), 32'd1);
    tick();
    check("lw_rd_state", 32'(bus.state), 32'd5);
    check("lw_rd_memrd", 32'(bus.MemRead), 32'd1);
    check("lw_rd_iord",  32'(bus.IorD), 32'd1);
    check("lw_rd_regw",  32'(bus.RegWrite), 32'd0);
    tick();
    check("lw_wb_state", 32'(bus.state), 32'd6);
    check("lw_wb_regw",  32'(bus.RegWrite), 32'd1);
    check("lw_wb_wd",    32'(bus.data_to_write), 32'b01);
    check("lw_wb_regdst", 32'(bus.RegDst), 32'b00);
    tick(); fetch_check("lw_fetch");

    // sw
    bus.opcode = 6'b101011;
    tick(); decode_check("sw", 1'b0);
    tick(); check("sw_adr_state", 32'(bus.state), 32'd4);
    tick();
    check("sw_wr_state", 32'(bus.state), 32'd7);
    check("sw_wr_memw",  32'(bus.MemWrite), 32'd1);
    check("sw_wr_iord",  32'(bus.IorD), 32'd1);
    check("sw_wr_memrd", 32'(bus.MemRead), 32'd0);
    tick(); fetch_check("sw_fetch");

    // beq with zero low then high: identical controls
    for (int z = 0; z < 2; z++) begin
      bus.opcode = 6'b000100;
      bus.zero   = z[0];
      tick(); decode_check("beq", 1'b0);
      tick();
      check("beq_state", 32'(bus.state), 32'd8);
      check("beq_alu",   32'(bus.alu_operation), 32'b110);
      check("beq_pwc",   32'(bus.PCWriteCond), 32'd1);
      check("beq_pcsrc", 32'(bus.PCSrc), 32'b01);
      check("beq_pcw",   32'(bus.PCWrite), 32'd0);
      tick(); fetch_check("beq_fetch");
    end
    bus.zero = 1'b0;

    // addi / slti
    for (int k = 0; k < 2; k++) begin
      bus.opcode = (k == 0) ? 6'b001000 : 6'b001010;
      tick(); decode_check("imm", 1'b0);
      tick();
      check("exi_state", 32'(bus.state), 32'd12);
      check("exi_alu",   32'(bus.alu_operation), (k == 0) ? 32'b010 : 32'b111);
      check("exi_srcb",  32'(bus.ALUSrcB), 32'b10);
      tick();
      check("wbi_state", 32'(bus.state), 32'd13);
      check("wbi_regw",  32'(bus.RegWrite), 32'd1);
      check("wbi_regdst", 32'(bus.RegDst), 32'b00);
      check("wbi_wd",    32'(bus.data_to_write), 32'b00);
      tick(); fetch_check("imm_fetch");
    end

    // j
    bus.opcode = 6'b000010;
    tick(); decode_check("j", 1'b0);
    tick();
    check("j_state", 32'(bus.state), 32'd9);
    check("j_pcw",   32'(bus.PCWrite), 32'd1);
    check("j_pcsrc", 32'(bus.PCSrc), 32'b10);
    check("j_regw",  32'(bus.RegWrite), 32'd0);
    tick(); fetch_check("j_fetch");

    // jal and jr
    bus.opcode = 6'b000011;
`ifdef MC_JUMP_LINK_EN
    tick(); decode_check("jal", 1'b0);
    tick();
    check("jal_state",  32'(bus.state), 32'd10);
    check("jal_regdst", 32'(bus.RegDst), 32'b10);
    check("jal_wd",     32'(bus.data_to_write), 32'b10);
    check("jal_regw",   32'(bus.RegWrite), 32'd1);
    check("jal_pcw",    32'(bus.PCWrite), 32'd1);
    check("jal_pcsrc",  32'(bus.PCSrc), 32'b10);
    tick(); fetch_check("jal_fetch");
    bus.opcode = 6'b000000;
    bus.func   = 6'b001000;
    tick(); decode_check("jr", 1'b0);
    tick();
    check("jr_state", 32'(bus.state), 32'd11);
    check("jr_pcsrc", 32'(bus.PCSrc), 32'b11);
    check("jr_pcw",   32'(bus.PCWrite), 32'd1);
    tick(); fetch_check("jr_fetch");
`else
    tick(); decode_check("jal_off", 1'b1);
    check("jal_off_regw", 32'(bus.RegWrite), 32'd0);
    tick(); fetch_check("jal_off_fetch");
    bus.opcode = 6'b000000;
    bus.func   = 6'b001000;
    tick(); decode_check("jr_off", 1'b1);
    tick(); fetch_check("jr_off_fetch");
`endif

    // Illegal opcode and illegal funct: two-cycle instructions
    bus.opcode = 6'b111111;
    tick(); decode_check("ill_op", 1'b1);
    tick(); fetch_check("ill_op_fetch");
    bus.opcode = 6'b000000;
    bus.func   = 6'b111111;
    tick(); decode_check("ill_fn", 1'b1);
    tick(); fetch_check("ill_fn_fetch");

    // Reset during MEM_ADR of sw: no MemWrite, restart at FETCH
    bus.opcode = 6'b101011;
    tick(); decode_check("swr", 1'b0);
    tick(); check("swr_adr_state", 32'(bus.state), 32'd4);
    rst = 1'b0;
    #1;
    check("swr_rst_outs", 32'(out_word), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("swr_rst_state", 32'(bus.state), 32'd0);
      check("swr_rst_memw",  32'(bus.MemWrite), 32'd0);
      check("swr_rst_outs",  32'(out_word), 32'd0);
    end
    rst = 1'b1;
    #1;
    fetch_check("swr_fetch");
    tick(); decode_check("swr2", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the team's MIPS core. It replaces the single-cycle controller once the datapath is refactored to share one ALU and one unified memory port across cycles. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back. Every cycle it drives the datapath mux selects, register and memory enables, and the ALU operation.

## Interface
Parameters:
- none (encodings live in the shared package)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-low reset
- opcode  input  6  inst[31:26] from the instruction register
- func  input  6  inst[5:0] from the instruction register
- zero  input  1  ALU zero flag
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction register load
- RegDst  output  2  write register select: 00 = rt, 01 = rd, 10 = $31
- data_to_write  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- alu_operation  output  3  ALU op code: 000 = and, 001 = or, 010 = add, 110 = sub, 111 = slt
- PCSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode or funct
- state  output  4  current state, for debug

## Operation
- States: FETCH, DECODE, EX_R, WB_R, MEM_ADR, MEM_RD, WB_LW, MEM_WR, BRANCH, JUMP, JAL, JR, EX_I, WB_I.
- FETCH actions: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00, PCWrite.
  - Next state: DECODE.
- DECODE actions: ALUSrcA=0, ALUSrcB=11, add (computes the branch target into ALUOut).
  - Dispatch by opcode:
    - 000000: EX_R; if func=001000, JR instead.
    - 100011 (lw) or 101011 (sw): MEM_ADR.
    - 000100 (beq): BRANCH.
    - 001000 (addi) or 001010 (slti): EX_I.
    - 000010 (j): JUMP.
    - 000011 (jal): JAL.
    - anything else: illegal_op=1, then FETCH.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALU op from func.
  - func codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other func: illegal_op was already pulsed in DECODE and the FSM goes to FETCH instead.
- WB_R: RegDst=01, data_to_write=00, RegWrite. Next: FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, add. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead, IorD=1. Next: WB_LW.
- WB_LW: RegDst=00, data_to_write=01, RegWrite. Next: FETCH.
- MEM_WR: MemWrite, IorD=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWriteCond. Next: FETCH.
- JUMP: PCSrc=10, PCWrite. Next: FETCH.
- JAL: PCSrc=10, PCWrite, RegDst=10, data_to_write=10, RegWrite. Next: FETCH.
  - The register write uses the PC value from before the update, which is already PC+4.
- JR: PCSrc=11, PCWrite. Next: FETCH.
- EX_I: ALUSrcA=1, ALUSrcB=10; add for addi, slt for slti.
- WB_I: RegDst=00, data_to_write=00, RegWrite. Next: FETCH.
- Outputs not listed for a state are 0. All outputs decode from state, opcode and func only. The datapath combines PCWriteCond with zero; this block never gates on zero.

## Timing
- rst low at a rising edge: the state register loads FETCH, and all outputs are 0 while rst is low.
- The first FETCH actions occur in the first cycle with rst high.
- Cycles per instruction, FETCH included:
  - R-type, addi, slti, sw: 4
  - lw: 5
  - beq, j, jal, jr: 3
  - illegal: 2
- opcode and func are sampled from the IR and must be stable from DECODE to the end of the instruction. IRWrite is asserted only in FETCH, which guarantees this.
- rst asserted mid-instruction: no further RegWrite or MemWrite pulse is emitted, and the FSM restarts at FETCH.
- illegal_op is high for exactly the one DECODE cycle.

## Configuration
- MC_JUMP_LINK_EN defined: the JAL and JR states exist and are decoded as above.
- Not defined: JAL and JR are removed, and jal and jr are treated as illegal (illegal_op pulse, then FETCH, no writes).
  - RegDst=10, data_to_write=10 and PCSrc=11 are never driven.

## Structure
- Package mips_mc_pkg holds:
  - the state enum
  - opcode and funct localparams
  - the alu_operation, PCSrc, RegDst, data_to_write and ALUSrcB encodings
- One sub-module, mc_alu_control: maps an ALU-op class (add, sub, funct, slt) plus func to alu_operation. It is combinational and instantiated once.
- The FSM next-state logic and output decode live in mips_mc_controller.

## Test plan
- Reset held 3 cycles, then released.
  - During reset: state=FETCH, all outputs 0.
  - First cycle after release: MemRead=1, IRWrite=1, PCWrite=1.
- opcode=000000, func=100000 (add): states FETCH→DECODE→EX_R→WB_R→FETCH.
  - alu_operation=010 in EX_R; RegWrite=1 with RegDst=01 only in WB_R.
- opcode=100011 (lw): 5-cycle sequence.
  - MemRead=1 with IorD=1 in MEM_RD.
  - RegWrite=1 with data_to_write=01 in WB_LW.
- opcode=000100 (beq): BRANCH reached in cycle 3 with alu_operation=110, PCWriteCond=1, PCSrc=01. Same result for zero=0 and zero=1.
- opcode=000011 (jal):
  - With MC_JUMP_LINK_EN: RegDst=10, data_to_write=10, RegWrite=1, PCWrite=1 in cycle 3.
  - Without it: illegal_op=1 in DECODE, and RegWrite stays 0.
- opcode=111111: illegal_op pulse in DECODE, then FETCH; reset asserted during MEM_ADR of an sw produces no MemWrite.
